// File: rtl/booth_digit_sequencer.sv
// Radix-16 Booth digit sequencer: load pulse, then one digit per cycle.
// Optional MUL_SIGNED_EN selects a two's-complement operand.
module booth_digit_sequencer #(
  parameter int WIDTH = 32,
`ifdef MUL_SIGNED_EN
  localparam int NDIG = WIDTH / 4,
`else
  localparam int NDIG = WIDTH / 4 + 1,
`endif
  localparam int IW = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplier_din,
  output logic             ready,
  output logic             load,
  output logic             digit_valid,
  output logic             digit_neg,
  output logic [3:0]       digit_mag,
  output logic [IW-1:0]    digit_idx,
  output logic             digit_last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH+4:0] sr;
  logic [WIDTH+4:0] sr_nxt;
  logic [IW-1:0]    cnt;
  logic [IW-1:0]    cnt_nxt;
  logic             ext;
  logic [4:0]       w;
  logic [3:0]       p;

`ifdef MUL_SIGNED_EN
  assign ext = multiplier_din[WIDTH-1];
`else
  assign ext = 1'b0;
`endif

  assign w = sr[4:0];
  assign p = {1'b0, w[3:1]} + {3'b000, w[0]};
  assign digit_idx = digit_valid ? cnt : '0;

  // State, operand shift register and digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and control outputs; top bit of sr is the fill bit
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    load        = 1'b0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          sr_nxt    = {{4{ext}}, multiplier_din, 1'b0};
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        digit_valid = 1'b1;
        sr_nxt  = {{4{sr[WIDTH+4]}}, sr[WIDTH+4:4]};
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          digit_last = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window to sign/magnitude; the all-ones window maps to +0
  always_comb begin
    digit_neg = 1'b0;
    digit_mag = 4'd0;
    unique case (1'b1)
      (!digit_valid): begin
        digit_neg = 1'b0;
        digit_mag = 4'd0;
      end
      (digit_valid && !w[4]): begin
        digit_mag = p;
      end
      (digit_valid && w[4] && p == 4'd8): begin
        digit_mag = 4'd0;
      end
      (digit_valid && w[4] && p != 4'd8): begin
        digit_neg = 1'b1;
        digit_mag = 4'd8 - p;
      end
    endcase
  end

endmodule
